clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Multi-channel programmable clock-enable generator for the FPGA top level.
//  It replaces fixed slow derived clocks with per-channel single-cycle tick enables
//  and registered square-wave levels, all in the single clk domain.
//  Each channel has a runtime divisor, high time and mode: RUN, HOLD, or STEP
//  (one period per step request, used to single-step the CPU core).
// PARAMETERS
//  NUM_CH       4         number of independent channels (1..16)
//  WIDTH        32        counter / divisor / high-time width in bits
//  DEFAULT_DIV  10000000  reset period in clk cycles, all channels
//  DEFAULT_HIGH 5000000   reset high time in clk cycles, all channels
//  RESET_MODE   2'b00     reset mode, all channels (00 RUN, 01 HOLD, 10 STEP)
// PORTS
//  clk       in   1                 system clock
//  reset_n   in   1                 asynchronous reset, active low
//  cfg_we    in   1                 config write strobe, one cycle
//  cfg_ch    in   $clog2(NUM_CH)    channel selected by cfg_we
//  cfg_div   in   WIDTH             new period P; 0 and 1 both mean P=1
//  cfg_high  in   WIDTH             new high time H in cycles
//  cfg_mode  in   2                 new mode
//  step      in   NUM_CH            per-channel step request pulse (STEP mode only)
//  tick      out  NUM_CH            one-cycle enable at end of each period, registered
//  level     out  NUM_CH            square wave, registered
//  busy      out  NUM_CH            STEP period in progress
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, P=DEFAULT_DIV, H=DEFAULT_HIGH,
//    mode=RESET_MODE. tick, level and busy are 0.
//  - RUN: cnt counts 0..P-1 and then wraps to 0.
//    tick is registered, so it is high for exactly 1 cycle after the edge where cnt==P-1.
//    The first tick after reset release is visible after edge P, then one every P cycles.
//  - level is registered and high for the first min(H,P) cycles of each period,
//    then low for the rest. H=0 gives level always 0. H>=P gives level always 1.
//    P=1 gives tick always 1.
//  - Config writes go to shadow registers. Shadow values load into active P/H/mode
//    on the next wrap.
//    A write in the same cycle as a wrap loads at that wrap, so it governs the next period.
//    A write to a channel in HOLD, or an idle STEP channel, loads on the next edge.
//    Back-to-back writes to one channel: the last write wins.
//    cfg_ch >= NUM_CH: the write is ignored.
//  - HOLD (and reserved 2'b11): cnt=0; tick, level and busy are 0.
//    Writing HOLD to a running channel takes effect immediately, without waiting for a
//    wrap: cnt clears and level drops on the next edge.
//  - STEP: while idle, cnt is held at 0 and level is 0.
//    A step pulse while idle sets busy and runs exactly one RUN period. That period
//    emits exactly one tick, after which busy clears on the same edge.
//    A step while busy is dropped, not queued.
//    A step in the same cycle as a config load uses the new P/H.
//  - A mode change to RUN or STEP from HOLD starts with cnt=0 on the next edge.
//  - Reset mid-period aborts the period. No tick is emitted.
//  - The counter is WIDTH bits with no overflow, because cnt < P <= 2^WIDTH-1.
// STRUCTURE
//  - Package clkgen_pkg:
//    - typedef enum logic[1:0] clkgen_mode_t {CLKGEN_RUN, CLKGEN_HOLD, CLKGEN_STEP, CLKGEN_RSVD}
//    - default constants
//  - Sub-module clkgen_channel (one per channel, generate loop) holds cnt, active and
//    shadow P/H/mode, and the step FSM. Step FSM states: IDLE, ACTIVE.
//  - The top holds cfg_ch decode and output packing.
// TESTING
//  1. DEFAULT_DIV=10, DEFAULT_HIGH=5, RUN -> first tick after edge 10, then every 10;
//     level 5 high / 5 low.
//  2. Mid-period write P=4, H=1 -> current 10-cycle period finishes unchanged, then
//     4-cycle periods with level 1 high / 3 low.
//  3. Edge cases: H=0 -> level constant 0; H=12 with P=10 -> constant 1;
//     P=0 -> tick every cycle.
//  4. STEP with P=6 -> idle with no ticks. Step pulse -> busy for 6 cycles, exactly one tick.
//     Second step at cycle 3 -> ignored, still one tick.
//  5. Write HOLD at cnt=7 -> next edge cnt=0 and level=0, no tick.
//     Write RUN -> restart from 0, first tick after P cycles.
//  6. Deassert reset_n at a random cycle mid-period -> all outputs 0 asynchronously.
//     Release -> defaults restored, cfg_ch=NUM_CH write ignored.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Purpose: shared types, reset defaults and mode helpers for the clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   clkgen_mode_t        channel mode encoding (RUN / HOLD / STEP / reserved)
//   clkgen_step_state_t  single-step FSM state
//   clkgen_out_t         per-channel registered outputs {tick, level, busy}
//   CLKGEN_DEFAULT_*     reset period, high time and mode
package clkgen_pkg;

  typedef enum logic [1:0] {
    CLKGEN_RUN  = 2'b00,
    CLKGEN_HOLD = 2'b01,
    CLKGEN_STEP = 2'b10,
    CLKGEN_RSVD = 2'b11
  } clkgen_mode_t;

  typedef enum logic {
    STEP_IDLE   = 1'b0,
    STEP_ACTIVE = 1'b1
  } clkgen_step_state_t;

  typedef struct packed {
    logic tick;
    logic level;
    logic busy;
  } clkgen_out_t;

  localparam int unsigned CLKGEN_DEFAULT_DIV  = 10000000;
  localparam int unsigned CLKGEN_DEFAULT_HIGH = 5000000;
  localparam logic [1:0]  CLKGEN_DEFAULT_MODE = 2'b00;
  localparam int          CLKGEN_MAX_CH       = 16;

  // The reserved encoding behaves exactly like HOLD.
  function automatic logic mode_is_stopped(input clkgen_mode_t m);
    return (m == CLKGEN_HOLD) || (m == CLKGEN_RSVD);
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// Purpose: one programmable clock-enable channel: counter, shadow/active config, step FSM.
// Latency: tick/level/busy are registered and describe the counter value of the previous cycle.
// Backpressure: none; config writes always accepted, step requests while busy are dropped.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   cfg_we         write strobe, already decoded for this channel
//   cfg_div        new period (0 and 1 both mean a period of one cycle)
//   cfg_high       new high time in cycles
//   cfg_mode       new mode
//   step           single-step request, honoured only by an idle STEP channel
//   ch_out         registered {tick, level, busy}
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(CLKGEN_DEFAULT_DIV),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = WIDTH'(CLKGEN_DEFAULT_HIGH),
  parameter logic [1:0]       RESET_MODE   = CLKGEN_DEFAULT_MODE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  clkgen_mode_t     cfg_mode,
  input  logic             step,
  output clkgen_out_t      ch_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Periods are stored already normalised so the wrap compare needs no special case.
  function automatic logic [WIDTH-1:0] norm_div(input logic [WIDTH-1:0] d);
    return (d <= ONE) ? ONE : d;
  endfunction

  localparam logic [WIDTH-1:0] P_RST    = norm_div(DEFAULT_DIV);
  localparam clkgen_mode_t     MODE_RST = clkgen_mode_t'(RESET_MODE);

  // Active configuration and counter
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   p_act;
  logic [WIDTH-1:0]   h_act;
  clkgen_mode_t       mode_act;

  // Shadow configuration, applied at the next wrap when pend is set
  logic [WIDTH-1:0]   sh_p;
  logic [WIDTH-1:0]   sh_h;
  clkgen_mode_t       sh_mode;
  logic               pend;

  clkgen_step_state_t state;
  logic               tick_q;
  logic               level_q;
  logic               busy_q;

  // Per-cycle decisions
  logic               counting;
  logic               wrap;
  logic               stop_wr;
  logic               load_now;
  logic               load_cfg;
  logic               load_sh;
  logic               step_go;
  clkgen_mode_t       next_mode;
  logic [WIDTH-1:0]   next_p;
  logic [WIDTH-1:0]   next_h;

  always_comb begin
    counting = (mode_act == CLKGEN_RUN) ||
               ((mode_act == CLKGEN_STEP) && (state == STEP_ACTIVE));
    // cnt < p_act always holds, so equality with p_act-1 is the end of the period.
    wrap     = counting && (cnt == p_act - ONE);
    stop_wr  = cfg_we && mode_is_stopped(cfg_mode);
    // A channel with no period in flight has nothing to protect, so it takes the
    // write straight away; a stopping write also cuts a running period short.
    load_now = cfg_we && (mode_is_stopped(mode_act) || stop_wr ||
                          ((mode_act == CLKGEN_STEP) && (state == STEP_IDLE)));
    // A write landing on the wrap cycle beats any older shadow value.
    load_cfg = load_now || (wrap && cfg_we);
    load_sh  = wrap && !cfg_we && pend;

    next_mode = mode_act;
    next_p    = p_act;
    next_h    = h_act;
    if (load_cfg) begin
      next_mode = cfg_mode;
      next_p    = norm_div(cfg_div);
      next_h    = cfg_high;
    end else if (load_sh) begin
      next_mode = sh_mode;
      next_p    = sh_p;
      next_h    = sh_h;
    end

    // Judged against the mode in force after this edge, so a step that coincides
    // with a config load runs with the newly loaded period and high time.
    step_go = step && (state == STEP_IDLE) && (next_mode == CLKGEN_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      p_act    <= P_RST;
      h_act    <= DEFAULT_HIGH;
      mode_act <= MODE_RST;
      sh_p     <= P_RST;
      sh_h     <= DEFAULT_HIGH;
      sh_mode  <= MODE_RST;
      pend     <= 1'b0;
      state    <= STEP_IDLE;
      tick_q   <= 1'b0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_act <= next_mode;
      p_act    <= next_p;
      h_act    <= next_h;

      // Shadow always tracks the latest write, so back-to-back writes resolve to the last.
      if (cfg_we) begin
        sh_p    <= norm_div(cfg_div);
        sh_h    <= cfg_high;
        sh_mode <= cfg_mode;
      end
      if (load_now || wrap) begin
        pend <= 1'b0;
      end else if (cfg_we) begin
        pend <= 1'b1;
      end

      // Counter and square-wave outputs
      if (!counting || stop_wr) begin
        cnt     <= '0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else begin
        level_q <= (cnt < h_act);
        if (wrap) begin
          cnt    <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + ONE;
          tick_q <= 1'b0;
        end
      end

      // Single-step FSM; busy mirrors ACTIVE and drops on the edge that emits the tick.
      if (stop_wr) begin
        state  <= STEP_IDLE;
        busy_q <= 1'b0;
      end else if (state == STEP_IDLE) begin
        if (step_go) begin
          state  <= STEP_ACTIVE;
          busy_q <= 1'b1;
        end
      end else if (wrap) begin
        state  <= STEP_IDLE;
        busy_q <= 1'b0;
      end
    end
  end

  assign ch_out.tick  = tick_q;
  assign ch_out.level = level_q;
  assign ch_out.busy  = busy_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Purpose: multi-channel programmable clock-enable generator (tick enables + square waves).
// Latency: outputs registered; config applies at the next wrap, or next edge when idle/stopping.
// Backpressure: none; one config write per cycle, writes to nonexistent channels are dropped.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   cfg_we/cfg_ch  write strobe and target channel
//   cfg_div        new period (0 and 1 mean one cycle)
//   cfg_high       new high time
//   cfg_mode       new mode (00 RUN, 01 HOLD, 10 STEP, 11 behaves as HOLD)
//   step           per-channel single-step request
//   tick           per-channel one-cycle enable at the end of each period
//   level          per-channel square wave
//   busy           per-channel STEP period in progress
module clk_enable_gen
  import clkgen_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = CLKGEN_DEFAULT_DIV,
  parameter int unsigned DEFAULT_HIGH = CLKGEN_DEFAULT_HIGH,
  parameter logic [1:0]  RESET_MODE   = CLKGEN_DEFAULT_MODE,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic [WIDTH-1:0]  cfg_high,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] busy
);

  clkgen_mode_t cfg_mode_e;
  clkgen_out_t  ch_out [NUM_CH];

  assign cfg_mode_e = clkgen_mode_t'(cfg_mode);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;

    // Only an exact match selects a channel; codes past NUM_CH-1 match nothing.
    assign ch_we = cfg_we && (int'(cfg_ch) == i);

    clkgen_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (WIDTH'(DEFAULT_DIV)),
      .DEFAULT_HIGH (WIDTH'(DEFAULT_HIGH)),
      .RESET_MODE   (RESET_MODE)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .cfg_we   (ch_we),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .cfg_mode (cfg_mode_e),
      .step     (step[i]),
      .ch_out   (ch_out[i])
    );

    assign tick[i]  = ch_out[i].tick;
    assign level[i] = ch_out[i].level;
    assign busy[i]  = ch_out[i].busy;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;
  import clkgen_pkg::*;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 32;

  logic              clk;
  logic              reset_n;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic [WIDTH-1:0]  cfg_high;
  logic [1:0]        cfg_mode;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] busy;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // rising edges since the last reset release

  clk_enable_gen #(
    .NUM_CH       (NUM_CH),
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (10),
    .DEFAULT_HIGH (5),
    .RESET_MODE   (2'b00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_mode (cfg_mode),
    .step     (step),
    .tick     (tick),
    .level    (level),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, got, exp);
    end
  endtask

  // Inputs change on the falling edge, outputs are read there too.
  task automatic adv();
    @(negedge clk);
    k++;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input logic [31:0] d, input logic [31:0] h,
                         input logic [1:0] m);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_high = h;
    cfg_mode = m;
  endtask

  initial begin
    logic et, el, eb, t12, l12;

    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_high = '0;
    cfg_mode = '0;
    step     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tick",  tick,  3'b000);
    chk("rst_level", level, 3'b000);
    chk("rst_busy",  busy,  3'b000);
    reset_n = 1'b1;
    k = 0;

    // Defaults P=10 H=5 RUN: tick after edge 10, 20; level high edges 1..5 of each period
    for (int i = 1; i <= 25; i++) begin
      adv();
      chk("run_tick0",  3'(tick[0]),  3'(k % 10 == 0));
      chk("run_level0", 3'(level[0]), 3'((k - 1) % 10 < 5));
      chk("run_busy",   busy, 3'b000);
    end

    // Mid-period write ch0 P=4 H=1 (edge 26), ch1 H=0 (edge 27); both load at the edge-30 wrap
    for (int i = 26; i <= 42; i++) begin
      if (i == 26)      set_cfg(2'd0, 4, 1, CLKGEN_RUN);
      else if (i == 27) set_cfg(2'd1, 10, 0, CLKGEN_RUN);
      else              cfg_we = 1'b0;
      adv();
      et = (k <= 30) ? (k == 30) : ((k - 30) % 4 == 0);
      el = (k <= 30) ? 1'b0 : ((k - 31) % 4 == 0);
      chk("p4_tick0",  3'(tick[0]),  3'(et));
      chk("p4_level0", 3'(level[0]), 3'(el));
      if (k >= 31) begin
        chk("h0_level1", 3'(level[1]), 3'b000);
        chk("h0_tick1",  3'(tick[1]),  3'(k == 40));
      end
    end

    // ch1: H=12 with P=10 (loads edge 50) -> level stuck high; then P=0 (loads edge 60) -> tick every cycle
    for (int i = 43; i <= 64; i++) begin
      if (i == 43)      set_cfg(2'd1, 10, 12, CLKGEN_RUN);
      else if (i == 56) set_cfg(2'd1, 0, 12, CLKGEN_RUN);
      else              cfg_we = 1'b0;
      adv();
      chk("hbig_level1", 3'(level[1]), 3'(k >= 51));
      chk("p0_tick1",    3'(tick[1]),  3'((k == 50) || (k >= 60)));
    end
    cfg_we = 1'b0;

    // ch2 still on defaults: HOLD written while cnt=7 (edge 68), RUN again at edge 73
    repeat (3) adv();
    for (int i = 68; i <= 83; i++) begin
      if (i == 68)      set_cfg(2'd2, 10, 5, CLKGEN_HOLD);
      else if (i == 73) set_cfg(2'd2, 10, 5, CLKGEN_RUN);
      else              cfg_we = 1'b0;
      adv();
      chk("hold_tick2",  3'(tick[2]),  3'(k == 83));
      chk("hold_level2", 3'(level[2]), 3'((k >= 74) && (k <= 78)));
      chk("hold_busy2",  3'(busy[2]),  3'b000);
    end

    // ch2 STEP P=6 H=3: idle, step at edge 90, second step at edge 93 while busy is dropped
    for (int i = 84; i <= 100; i++) begin
      if (i == 84)      set_cfg(2'd2, 10, 5, CLKGEN_HOLD);
      else if (i == 85) set_cfg(2'd2, 6, 3, CLKGEN_STEP);
      else              cfg_we = 1'b0;
      step = ((i == 90) || (i == 93)) ? 3'b100 : 3'b000;
      adv();
      eb = (k >= 90) && (k <= 95);
      chk("step_busy2",  3'(busy[2]),  3'(eb));
      chk("step_tick2",  3'(tick[2]),  3'(k == 96));
      chk("step_level2", 3'(level[2]), 3'((k >= 91) && (k <= 93)));
    end
    step   = '0;
    cfg_we = 1'b0;

    // Asynchronous reset mid-period; ch1 (P=1, H=12) has tick and level high beforehand
    repeat ($urandom_range(1, 5)) adv();
    chk("prerst_tick1",  3'(tick[1]),  3'b001);
    chk("prerst_level1", 3'(level[1]), 3'b001);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tick",  tick,  3'b000);
    chk("arst_level", level, 3'b000);
    chk("arst_busy",  busy,  3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    k = 0;

    // Defaults back; write to cfg_ch=3 ignored; two writes to ch0, last one (P=5 H=2) loads at edge 10
    for (int i = 1; i <= 20; i++) begin
      if (i == 1)      set_cfg(2'd3, 2, 1, CLKGEN_RUN);
      else if (i == 2) set_cfg(2'd0, 3, 1, CLKGEN_RUN);
      else if (i == 3) set_cfg(2'd0, 5, 2, CLKGEN_RUN);
      else             cfg_we = 1'b0;
      adv();
      t12 = (k == 10) || (k == 20);
      l12 = ((k - 1) % 10 < 5);
      et  = t12 || (k == 15);
      el  = (k <= 10) ? l12 : ((k - 11) % 5 < 2);
      chk("post_tick",  tick,  {t12, t12, et});
      chk("post_level", level, {l12, l12, el});
      chk("post_busy",  busy,  3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
